// File: rtl/switch_capture_bank_pkg.sv
// Shared types and width helpers for the switch capture bank.
// Imported by the interface, the debouncer's parent and the top level.
package switch_capture_pkg;

  // LED view: live switches or one stored snapshot
  typedef enum logic {
    VIEW_LIVE = 1'b0,
    VIEW_SLOT = 1'b1
  } view_state_e;

  // Bits needed to address one snapshot slot
  function automatic int ptrWidth(input int depth);
    return $clog2(depth);
  endfunction

  // Bits needed to hold 0..DEPTH valid snapshots
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/switch_capture_bank_if.sv
// Board-side bundle for the switch capture bank: raw switches and buttons in,
// LED word and status out. The master modport is the board/stimulus side,
// the slave modport is the capture bank itself.
interface switch_capture_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import switch_capture_pkg::*;

  localparam int PW = ptrWidth(DEPTH);
  localparam int CW = countWidth(DEPTH);

  logic [WIDTH-1:0] data;
  logic             btn1;
  logic             btn0;
  logic [WIDTH-1:0] led;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic [CW-1:0]    count;
  logic             view_live;
  logic [PW-1:0]    view_idx;

  modport master (
    output data, btn1, btn0,
    input  led, Q, Qn, count, view_live, view_idx
  );

  modport slave (
    input  data, btn1, btn0,
    output led, Q, Qn, count, view_live, view_idx
  );

endinterface

// File: rtl/switch_capture_bank_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition of the stable level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNTW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]      r_sync;
  logic            r_stable;
  logic [CNTW-1:0] r_cnt;
  logic            r_pulse;

  logic w_synced;
  logic w_differ;
  logic w_expire;

  assign w_synced = r_sync[1];
  assign w_differ = (w_synced != r_stable);
  assign w_expire = w_differ && (r_cnt == CNTW'(DEBOUNCE_CYCLES - 1));

  // Bring the raw pin into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_btn};
  end

  // Count consecutive differing samples; flip the stable level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      if (!w_differ || w_expire) r_cnt <= '0;
      else                       r_cnt <= r_cnt + 1'b1;
      if (w_expire) r_stable <= w_synced;
      r_pulse <= w_expire && w_synced;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/switch_capture_bank.sv
// Switch capture bank: stores switch words into a circular snapshot bank on
// debounced presses of btn1 and steps the LED view with btn0.
// Build option SNAPSHOT_LOCK_EN: once the bank is full further captures are
// ignored until reset; otherwise the oldest snapshot is overwritten.
module switch_capture_bank #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                 clk,
  input logic                 rst_n,
  switch_capture_bank_if.slave bus
);
  import switch_capture_pkg::*;

  localparam int PW = ptrWidth(DEPTH);
  localparam int CW = countWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_ledSlot;
  view_state_e      r_viewState;
  logic [PW-1:0]    r_viewIdx;

  view_state_e      w_viewStateNext;
  logic [PW-1:0]    w_viewIdxNext;
  logic             w_capPulse;
  logic             w_selPulse;
  logic             w_doCapture;
  logic             w_full;
  logic [PW-1:0]    w_physIdx;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_capBtn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn1),
    .o_pulse(w_capPulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_selBtn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn0),
    .o_pulse(w_selPulse)
  );

  assign w_full = (r_count == CW'(DEPTH));

`ifdef SNAPSHOT_LOCK_EN
  assign w_doCapture = w_capPulse && !w_full;
`else
  assign w_doCapture = w_capPulse;
`endif

  // Age 0 is the oldest snapshot, which sits count slots behind the write pointer
  assign w_physIdx = r_wrPtr - r_count[PW-1:0] + r_viewIdx;

  // Snapshot storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_doCapture) begin
      r_mem[r_wrPtr] <= bus.data;
    end
  end

  // Write pointer, saturating fill count and latest-snapshot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_count <= '0;
      r_q     <= '0;
    end else if (w_doCapture) begin
      r_wrPtr <= r_wrPtr + 1'b1;
      if (!w_full) r_count <= r_count + 1'b1;
      r_q <= bus.data;
    end
  end

  // View FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_viewState <= VIEW_LIVE;
      r_viewIdx   <= '0;
    end else begin
      r_viewState <= w_viewStateNext;
      r_viewIdx   <= w_viewIdxNext;
    end
  end

  // View FSM next state; uses the count from before any same-cycle capture
  always_comb begin
    w_viewStateNext = r_viewState;
    w_viewIdxNext   = r_viewIdx;
    case (r_viewState)
      VIEW_LIVE: begin
        if (w_selPulse && (r_count != '0)) begin
          w_viewStateNext = VIEW_SLOT;
          w_viewIdxNext   = '0;
        end
      end
      VIEW_SLOT: begin
        if (w_selPulse) begin
          if (CW'(r_viewIdx) == (r_count - CW'(1))) begin
            w_viewStateNext = VIEW_LIVE;
            w_viewIdxNext   = '0;
          end else begin
            w_viewIdxNext = r_viewIdx + 1'b1;
          end
        end
      end
      default: begin
        w_viewStateNext = VIEW_LIVE;
        w_viewIdxNext   = '0;
      end
    endcase
  end

  // Registered read of the snapshot currently being viewed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ledSlot <= '0;
    else        r_ledSlot <= r_mem[w_physIdx];
  end

  assign bus.led       = (r_viewState == VIEW_LIVE) ? bus.data : r_ledSlot;
  assign bus.Q         = r_q;
  assign bus.Qn        = ~r_q;
  assign bus.count     = r_count;
  assign bus.view_live = (r_viewState == VIEW_LIVE);
  assign bus.view_idx  = r_viewIdx;

endmodule

// File: tb/tb_switch_capture_bank.sv
// Directed bench for switch_capture_bank with WIDTH=8, DEPTH=4 and a short
// debounce window. Expected values are hand-computed constants; the lock
// variant is selected with the same SNAPSHOT_LOCK_EN define as the design.
module tb_switch_capture_bank;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  switch_capture_bank_if #(.WIDTH(8), .DEPTH(4)) bus ();

  switch_capture_bank #(
    .WIDTH          (8),
    .DEPTH          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Hold the selected buttons for holdCycles, then release and let them settle
  task automatic applyStimulus(input logic [1:0] buttons, input int holdCycles);
    bus.btn1 = buttons[1];
    bus.btn0 = buttons[0];
    repeat (holdCycles) @(negedge clk);
    bus.btn1 = 1'b0;
    bus.btn0 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic captureWord(input logic [7:0] value);
    bus.data = value;
    applyStimulus(2'b10, 8);
  endtask

  task automatic pressSelect();
    applyStimulus(2'b01, 8);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Directed test sequence
  initial begin
    testCount = 0;
    failCount = 0;
    bus.data  = 8'hFF;
    bus.btn1  = 1'b0;
    bus.btn0  = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    resetDut();

    checkOutput("reset_led",   32'(bus.led),       32'hFF);
    checkOutput("reset_Q",     32'(bus.Q),         32'h00);
    checkOutput("reset_Qn",    32'(bus.Qn),        32'hFF);
    checkOutput("reset_count", 32'(bus.count),     32'd0);
    checkOutput("reset_live",  32'(bus.view_live), 32'd1);
    checkOutput("reset_idx",   32'(bus.view_idx),  32'd0);

    pressSelect();
    checkOutput("empty_select_live", 32'(bus.view_live), 32'd1);

    bus.data = 8'h3C;
    #1;
    checkOutput("live_passthrough", 32'(bus.led), 32'h3C);

    // Bounce 1,0,1 then steady high: one capture only
    bus.data = 8'hA5;
    bus.btn1 = 1'b1;
    @(negedge clk);
    bus.btn1 = 1'b0;
    @(negedge clk);
    applyStimulus(2'b10, 10);
    checkOutput("bounce_count", 32'(bus.count), 32'd1);
    checkOutput("bounce_Q",     32'(bus.Q),     32'hA5);
    checkOutput("bounce_Qn",    32'(bus.Qn),    32'h5A);

    // Three-cycle glitch is too short to qualify
    bus.data = 8'h77;
    applyStimulus(2'b10, 3);
    checkOutput("glitch_count", 32'(bus.count), 32'd1);
    checkOutput("glitch_Q",     32'(bus.Q),     32'hA5);

    // Fill past capacity and walk the view
    resetDut();
    captureWord(8'h11);
    captureWord(8'h22);
    captureWord(8'h33);
    captureWord(8'h44);
    captureWord(8'h55);
    checkOutput("full_count", 32'(bus.count), 32'd4);
`ifdef SNAPSHOT_LOCK_EN
    checkOutput("full_Q", 32'(bus.Q), 32'h44);
    pressSelect();
    checkOutput("slot0_led", 32'(bus.led), 32'h11);
    checkOutput("slot0_idx", 32'(bus.view_idx), 32'd0);
    pressSelect();
    checkOutput("slot1_led", 32'(bus.led), 32'h22);
    pressSelect();
    checkOutput("slot2_led", 32'(bus.led), 32'h33);
    pressSelect();
    checkOutput("slot3_led", 32'(bus.led), 32'h44);
    checkOutput("slot3_idx", 32'(bus.view_idx), 32'd3);
`else
    checkOutput("full_Q", 32'(bus.Q), 32'h55);
    pressSelect();
    checkOutput("slot0_led", 32'(bus.led), 32'h22);
    checkOutput("slot0_idx", 32'(bus.view_idx), 32'd0);
    pressSelect();
    checkOutput("slot1_led", 32'(bus.led), 32'h33);
    pressSelect();
    checkOutput("slot2_led", 32'(bus.led), 32'h44);
    pressSelect();
    checkOutput("slot3_led", 32'(bus.led), 32'h55);
    checkOutput("slot3_idx", 32'(bus.view_idx), 32'd3);
`endif
    checkOutput("slot3_notlive", 32'(bus.view_live), 32'd0);
    bus.data = 8'h5A;
    pressSelect();
    checkOutput("wrap_live",     32'(bus.view_live), 32'd1);
    checkOutput("wrap_live_led", 32'(bus.led),       32'h5A);

    // Capture while viewing the oldest slot of a full bank
    pressSelect();
    captureWord(8'h66);
    checkOutput("ovw_idx",   32'(bus.view_idx), 32'd0);
    checkOutput("ovw_count", 32'(bus.count),    32'd4);
`ifdef SNAPSHOT_LOCK_EN
    checkOutput("ovw_led", 32'(bus.led), 32'h11);
    checkOutput("ovw_Q",   32'(bus.Q),   32'h44);
`else
    checkOutput("ovw_led", 32'(bus.led), 32'h33);
    checkOutput("ovw_Q",   32'(bus.Q),   32'h66);
`endif

    // Simultaneous capture and select at the last valid slot
    resetDut();
    captureWord(8'hAA);
    captureWord(8'hBB);
    pressSelect();
    pressSelect();
    checkOutput("pre_both_idx", 32'(bus.view_idx), 32'd1);
    checkOutput("pre_both_led", 32'(bus.led),      32'hBB);
    bus.data = 8'hCC;
    applyStimulus(2'b11, 8);
    checkOutput("both_live",  32'(bus.view_live), 32'd1);
    checkOutput("both_count", 32'(bus.count),     32'd3);
    checkOutput("both_Q",     32'(bus.Q),         32'hCC);

    // Reset mid-view with the capture button held
    resetDut();
    captureWord(8'h77);
    pressSelect();
    checkOutput("midview_led", 32'(bus.led), 32'h77);
    bus.data = 8'h99;
    bus.btn1 = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_led",   32'(bus.led),       32'h99);
    checkOutput("async_Q",     32'(bus.Q),         32'h00);
    checkOutput("async_Qn",    32'(bus.Qn),        32'hFF);
    checkOutput("async_count", 32'(bus.count),     32'd0);
    checkOutput("async_live",  32'(bus.view_live), 32'd1);
    checkOutput("async_idx",   32'(bus.view_idx),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("requal_count", 32'(bus.count), 32'd1);
    checkOutput("requal_Q",     32'(bus.Q),     32'h99);
    bus.btn1 = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("requal_once", 32'(bus.count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
